// File: rtl/settings_menu_nav.sv
// Keypad-driven settings menu: opens on key 0, moves a wrapping cursor with
// edge steps plus hold-to-repeat, and ends in a one-cycle commit or cancel pulse.
module settings_menu_nav #(
    parameter int NUM_OPTIONS  = 4,
    parameter int REPEAT_DELAY = 12_500_000,
    parameter int REPEAT_RATE  = 3_125_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] key_is_pressed,
    output logic [2:0] hovered_idx,
    output logic       menu_active,
    output logic       cursor_moved,
    output logic       settings_commit,
    output logic       menu_cancel,
    output logic [1:0] dbg_state
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DELAY_M1 = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_M1  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
    localparam logic [2:0]       LAST_IDX = 3'(NUM_OPTIONS - 1);
    localparam logic [2:0]       IDX_NONE = 3'd7;

    localparam int K_CANCEL = 0;
    localparam int K_DOWN   = 2;
    localparam int K_SELECT = 5;
    localparam int K_UP     = 8;

    typedef enum logic [1:0] {
        S_CLOSED = 2'd0,
        S_OPEN   = 2'd1,
        S_COMMIT = 2'd2,
        S_CANCEL = 2'd3
    } state_t;

    state_t           state_q;
    logic [9:0]       key_q;
    logic [2:0]       hovered_idx_q;
    logic             menu_active_q;
    logic             cursor_moved_q;
    logic             settings_commit_q;
    logic             menu_cancel_q;
    logic [CNT_W-1:0] cnt_q;
    logic             armed_q;
    logic             phase_q;

    logic [9:0] rise;
    logic       up_now, dn_now, up_prev, dn_prev;
    logic       up_edge, dn_edge;
    logic       repeat_due;
    logic       step_up, step_dn;
    logic [2:0] idx_up_d, idx_dn_d;
    logic [CNT_W-1:0] cnt_inc_d;

    always_comb begin
        rise     = key_is_pressed & ~key_q;
        up_now   = key_is_pressed[K_UP] & ~key_is_pressed[K_DOWN];
        dn_now   = key_is_pressed[K_DOWN] & ~key_is_pressed[K_UP];
        up_prev  = key_q[K_UP] & ~key_q[K_DOWN];
        dn_prev  = key_q[K_DOWN] & ~key_q[K_UP];
        up_edge  = up_now & ~up_prev;
        dn_edge  = dn_now & ~dn_prev;

        // Repeats only run after an edge step armed them and the same single
        // direction has been held since; a direction change shows up as an edge.
        repeat_due = armed_q && (up_now || dn_now) && !(up_edge || dn_edge) &&
                     (phase_q ? (cnt_q == RATE_M1) : (cnt_q == DELAY_M1));

        step_up = up_edge | (repeat_due & up_now);
        step_dn = dn_edge | (repeat_due & dn_now);

        idx_up_d  = (hovered_idx_q == 3'd0) ? LAST_IDX : hovered_idx_q - 3'd1;
        idx_dn_d  = (hovered_idx_q == LAST_IDX) ? 3'd0 : hovered_idx_q + 3'd1;
        cnt_inc_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= S_CLOSED;
            key_q             <= '0;
            hovered_idx_q     <= IDX_NONE;
            menu_active_q     <= 1'b0;
            cursor_moved_q    <= 1'b0;
            settings_commit_q <= 1'b0;
            menu_cancel_q     <= 1'b0;
            cnt_q             <= '0;
            armed_q           <= 1'b0;
            phase_q           <= 1'b0;
        end else begin
            key_q             <= key_is_pressed;
            cursor_moved_q    <= 1'b0;
            settings_commit_q <= 1'b0;
            menu_cancel_q     <= 1'b0;

            case (state_q)
                S_CLOSED: begin
                    cnt_q   <= '0;
                    armed_q <= 1'b0;
                    phase_q <= 1'b0;
                    if (rise[K_CANCEL]) begin
                        state_q       <= S_OPEN;
                        hovered_idx_q <= 3'd0;
                        menu_active_q <= 1'b1;
                    end
                end

                S_OPEN: begin
                    // Select wins over cancel, and either one swallows movement.
                    if (rise[K_SELECT]) begin
                        state_q           <= S_COMMIT;
                        settings_commit_q <= 1'b1;
                        hovered_idx_q     <= IDX_NONE;
                        menu_active_q     <= 1'b0;
                        cnt_q             <= '0;
                        armed_q           <= 1'b0;
                        phase_q           <= 1'b0;
                    end else if (rise[K_CANCEL]) begin
                        state_q       <= S_CANCEL;
                        menu_cancel_q <= 1'b1;
                        hovered_idx_q <= IDX_NONE;
                        menu_active_q <= 1'b0;
                        cnt_q         <= '0;
                        armed_q       <= 1'b0;
                        phase_q       <= 1'b0;
                    end else if (step_up || step_dn) begin
                        hovered_idx_q  <= step_up ? idx_up_d : idx_dn_d;
                        cursor_moved_q <= 1'b1;
                        cnt_q          <= '0;
                        armed_q        <= 1'b1;
                        phase_q        <= repeat_due;
                    end else if (armed_q && (up_now || dn_now)) begin
                        cnt_q <= cnt_inc_d;
                    end else begin
                        cnt_q   <= '0;
                        armed_q <= 1'b0;
                        phase_q <= 1'b0;
                    end
                end

                S_COMMIT: begin
                    state_q <= S_CLOSED;
                end

                S_CANCEL: begin
                    state_q <= S_CLOSED;
                end

                default: begin
                    state_q       <= S_CLOSED;
                    hovered_idx_q <= IDX_NONE;
                    menu_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign hovered_idx     = hovered_idx_q;
    assign menu_active     = menu_active_q;
    assign cursor_moved    = cursor_moved_q;
    assign settings_commit = settings_commit_q;
    assign menu_cancel     = menu_cancel_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_settings_menu_nav.sv
// Directed bench for settings_menu_nav with NUM_OPTIONS=4, REPEAT_DELAY=10, REPEAT_RATE=4.
module tb_settings_menu_nav;

    logic       clk;
    logic       reset;
    logic [9:0] keys;
    logic [2:0] hovered_idx;
    logic       menu_active;
    logic       cursor_moved;
    logic       settings_commit;
    logic       menu_cancel;
    logic [1:0] dbg_state;

    int errors = 0;
    int checks = 0;

    settings_menu_nav #(
        .NUM_OPTIONS (4),
        .REPEAT_DELAY(10),
        .REPEAT_RATE (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .key_is_pressed (keys),
        .hovered_idx    (hovered_idx),
        .menu_active    (menu_active),
        .cursor_moved   (cursor_moved),
        .settings_commit(settings_commit),
        .menu_cancel    (menu_cancel),
        .dbg_state      (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_closed(input string tag);
        check({tag, "_idx"}, 32'(hovered_idx), 32'd7);
        check({tag, "_active"}, 32'(menu_active), 32'd0);
    endtask

    // Press one key for a single cycle, expecting one cursor step to exp_idx.
    task automatic press_step(input int bit_n, input int exp_idx);
        keys = '0;
        keys[bit_n] = 1'b1;
        tick();
        check("step_idx", 32'(hovered_idx), 32'(exp_idx));
        check("step_moved", 32'(cursor_moved), 32'd1);
        keys = '0;
        tick();
        check("step_hold_idx", 32'(hovered_idx), 32'(exp_idx));
        check("step_moved_clear", 32'(cursor_moved), 32'd0);
    endtask

    initial begin
        int exp_idx;
        logic exp_mv;

        reset = 1'b1;
        keys  = '0;
        tick();
        tick();
        check_closed("reset");
        check("reset_moved", 32'(cursor_moved), 32'd0);
        check("reset_commit", 32'(settings_commit), 32'd0);
        check("reset_cancel", 32'(menu_cancel), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);

        reset = 1'b0;
        tick();
        check_closed("post_reset");

        // Open, then step down three times.
        keys = 10'b00_0000_0001;
        tick();
        check("open_idx", 32'(hovered_idx), 32'd0);
        check("open_active", 32'(menu_active), 32'd1);
        check("open_state", 32'(dbg_state), 32'd1);
        check("open_moved", 32'(cursor_moved), 32'd0);
        keys = '0;
        tick();
        press_step(2, 1);
        press_step(2, 2);
        press_step(2, 3);

        // Wrap both ways.
        press_step(2, 0);
        press_step(8, 3);
        press_step(2, 0);

        // Auto-repeat: hold down 30 cycles from idx 0.
        exp_idx = 0;
        keys = 10'b00_0000_0100;
        for (int i = 0; i < 30; i++) begin
            tick();
            exp_mv = (i == 0) || (i >= 10 && ((i - 10) % 4) == 0);
            if (exp_mv) exp_idx = (exp_idx + 1) % 4;
            check("rep_moved", 32'(cursor_moved), 32'(exp_mv));
            check("rep_idx", 32'(hovered_idx), 32'(exp_idx));
        end
        check("rep_final_idx", 32'(hovered_idx), 32'd2);
        keys = '0;
        tick();
        check("rep_release_moved", 32'(cursor_moved), 32'd0);
        press_step(2, 3);

        // Up and down together: no movement.
        keys = 10'b01_0000_0100;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("both_moved", 32'(cursor_moved), 32'd0);
            check("both_idx", 32'(hovered_idx), 32'd3);
        end
        keys = '0;
        tick();
        check("both_release_moved", 32'(cursor_moved), 32'd0);

        // Select and cancel edges together: commit wins.
        keys = 10'b00_0010_0001;
        tick();
        check("commit_pulse", 32'(settings_commit), 32'd1);
        check("commit_no_cancel", 32'(menu_cancel), 32'd0);
        check("commit_state", 32'(dbg_state), 32'd2);
        check_closed("commit");
        keys = '0;
        tick();
        check("commit_pulse_end", 32'(settings_commit), 32'd0);
        check("commit_to_closed", 32'(dbg_state), 32'd0);
        check_closed("after_commit");

        // Cancel path.
        keys = 10'b00_0000_0001;
        tick();
        check("reopen_idx", 32'(hovered_idx), 32'd0);
        keys = '0;
        tick();
        keys = 10'b00_0000_0001;
        tick();
        check("cancel_pulse", 32'(menu_cancel), 32'd1);
        check("cancel_no_commit", 32'(settings_commit), 32'd0);
        check("cancel_state", 32'(dbg_state), 32'd3);
        check_closed("cancel");
        keys = '0;
        tick();
        check("cancel_pulse_end", 32'(menu_cancel), 32'd0);
        check("cancel_no_commit2", 32'(settings_commit), 32'd0);
        check_closed("after_cancel");

        // Down held while closed is ignored and does not step or repeat after open.
        keys = 10'b00_0000_0100;
        tick();
        check_closed("closed_down");
        check("closed_down_moved", 32'(cursor_moved), 32'd0);
        keys = 10'b00_0000_0101;
        tick();
        check("held_open_idx", 32'(hovered_idx), 32'd0);
        check("held_open_moved", 32'(cursor_moved), 32'd0);
        keys = 10'b00_0000_0100;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("held_no_step", 32'(cursor_moved), 32'd0);
        end
        check("held_idx", 32'(hovered_idx), 32'd0);
        keys = '0;
        tick();

        // Reset in the middle of a repeat run.
        exp_idx = 0;
        keys = 10'b00_0000_0100;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_mv = (i == 0) || (i == 10);
            if (exp_mv) exp_idx = exp_idx + 1;
            check("rr_moved", 32'(cursor_moved), 32'(exp_mv));
        end
        check("rr_idx", 32'(hovered_idx), 32'(exp_idx));
        reset = 1'b1;
        tick();
        check_closed("rr_reset");
        check("rr_moved_zero", 32'(cursor_moved), 32'd0);
        check("rr_commit_zero", 32'(settings_commit), 32'd0);
        check("rr_cancel_zero", 32'(menu_cancel), 32'd0);
        keys = 10'b00_0000_0001;
        tick();
        check_closed("rr_in_reset");
        reset = 1'b0;
        tick();
        check("rr_open_idx", 32'(hovered_idx), 32'd0);
        check("rr_open_active", 32'(menu_active), 32'd1);
        keys = '0;
        tick();
        check("rr_stay_open", 32'(menu_active), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/settings_menu_nav.md
SETTINGS_MENU_NAV -- requirements
Module: settings_menu_nav

Interface
REQ-001 Parameter NUM_OPTIONS, default 4, number of selectable rows; legal range 1..7.
REQ-002 Parameter REPEAT_DELAY, default 12_500_000, continuous-hold cycles before the first auto-repeat step; legal range >= 2.
REQ-003 Parameter REPEAT_RATE, default 3_125_000, cycles between subsequent auto-repeat steps; legal range >= 1.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 key_is_pressed  input  10  keypad level vector; bit 8 = up, bit 2 = down, bit 5 = select, bit 0 = menu open/cancel.
REQ-008 hovered_idx  output  3  highlighted row index; 3'd7 when the menu is closed.
REQ-009 menu_active  output  1  high while the menu is open.
REQ-010 cursor_moved  output  1  one-cycle pulse on every cursor step.
REQ-011 settings_commit  output  1  one-cycle pulse when the user confirms the settings.
REQ-012 menu_cancel  output  1  one-cycle pulse when the user closes the menu without confirming.

Function
REQ-013 Key edges: register key_is_pressed every cycle; rise[k] = key[k] & ~key_d[k].
REQ-014 FSM states: CLOSED, OPEN, COMMIT, CANCEL.
REQ-015 CLOSED: hovered_idx = 7 and menu_active = 0; rise[0] -> OPEN, loading hovered_idx = 0 in the same edge.
REQ-016 OPEN: menu_active = 1; rise[5] -> COMMIT; else rise[0] -> CANCEL; else process cursor movement.
REQ-017 Select priority: rise[5] and rise[0] in the same cycle -> COMMIT.
REQ-018 Select/cancel vs. movement: a select or cancel edge suppresses any movement in that cycle.
REQ-019 COMMIT: settings_commit = 1 for exactly one cycle, hovered_idx = 7, menu_active = 0; next state CLOSED.
REQ-020 CANCEL: menu_cancel = 1 for exactly one cycle, hovered_idx = 7, menu_active = 0; next state CLOSED.
REQ-021 Direction: "up held" = key[8] & ~key[2]; "down held" = key[2] & ~key[8]; both or neither = no direction.
REQ-022 Step on edge: in OPEN, a rising edge of "up held" decrements hovered_idx and a rising edge of "down held" increments it, effective next cycle.
REQ-023 Wrap-around: up from 0 -> NUM_OPTIONS-1; down from NUM_OPTIONS-1 -> 0; NUM_OPTIONS = 1 keeps index 0 but still pulses cursor_moved.
REQ-024 Hold counter, first repeat: while a single direction stays held, a counter runs from the edge step; the first repeat step occurs REPEAT_DELAY cycles after the edge step.
REQ-025 Hold counter, later repeats: subsequent steps occur every REPEAT_RATE cycles thereafter.
REQ-026 Hold counter clear: counter and repeat phase clear when the direction changes, when no direction is held, or on leaving OPEN.
REQ-027 Counter width: $clog2(max(REPEAT_DELAY, REPEAT_RATE) + 1) bits; the counter saturates and never wraps.
REQ-028 cursor_moved: high in the same cycle hovered_idx is updated, once per step.
REQ-029 Outputs are registered: hovered_idx, menu_active and all pulses come from flops.
REQ-030 Keys in CLOSED: keys other than bit 0 are ignored; held keys at menu open cause no step until a new edge.

Reset
REQ-031 Reset values: state = CLOSED, hovered_idx = 3'd7, menu_active = 0, cursor_moved = 0, settings_commit = 0, menu_cancel = 0, key_d = 0, hold counter = 0.
REQ-032 Reset asserted mid-menu or mid-repeat: outputs return to reset values on the next edge.
REQ-033 Key held through reset release: a key held through reset release registers as a rising edge on the first post-reset cycle.

Verification (NUM_OPTIONS=4, REPEAT_DELAY=10, REPEAT_RATE=4)
REQ-034 Open and step: pulse key 0 -> hovered_idx 0, menu_active 1; pulse key 2 three times -> 1, 2, 3, with one cursor_moved per step.
REQ-035 Wrap: at idx 3 pulse down -> 0; pulse up -> 3.
REQ-036 Auto-repeat: hold down for 30 cycles from idx 0 -> steps at cycles 0, 10, 14, 18, 22, 26; final idx 2 after 6 steps; release then re-press -> immediate step.
REQ-037 Simultaneous keys: hold up+down -> no movement and no cursor_moved; rise[5]+rise[0] together -> settings_commit pulse only, then hovered_idx 7.
REQ-038 Cancel: open menu, pulse key 0 -> menu_cancel one cycle, menu_active 0, hovered_idx 7, settings_commit never asserted.
REQ-039 Reset during repeat: hold down, assert reset at cycle 12 -> next cycle hovered_idx 7 and all pulses 0; release reset with key 0 held -> menu opens next cycle.
